// File: rtl/clken_gen.sv
// Programmable clock-enable generator: one-cycle tick every N cycles,
// near-50% square output, pulse counter, boundary-aligned divisor updates.
module clken_gen #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 5,
  parameter int TICK_W  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_val,
  input  logic              div_load,
  output logic              clk_flag,
  output logic              clk_sq,
  output logic              upd_pend,
  output logic [TICK_W-1:0] tick_cnt,
  output logic [CNT_W-1:0]  cur_div
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   ONEW = (CNT_W+1)'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] n_eff;
  logic [CNT_W-1:0] n_new;
  logic [CNT_W-1:0] div_in;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   half;
  logic             wrap;

  always_comb begin
    n_eff   = (cur_div == '0) ? ONE : cur_div;
    div_in  = (div_val == '0) ? ONE : div_val;
    wrap    = (cnt >= n_eff - ONE);
    cnt_nxt = wrap ? '0 : cnt + ONE;
    // The period starting at a wrap edge already uses the committed divisor
    n_new   = (wrap && upd_pend) ? pend_div : n_eff;
    half    = ({1'b0, n_new} + ONEW) >> 1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt      <= '0;
      pend_div <= '0;
      cur_div  <= CNT_W'(DEF_DIV);
      upd_pend <= 1'b0;
      clk_flag <= 1'b0;
      clk_sq   <= 1'b0;
      tick_cnt <= '0;
    end else if (en) begin
      cnt      <= cnt_nxt;
      clk_flag <= wrap;
      clk_sq   <= ({1'b0, cnt_nxt} < half);
      if (wrap) begin
        tick_cnt <= tick_cnt + TICK_W'(1);
        if (upd_pend) cur_div <= pend_div;
      end
      if (div_load) begin
        pend_div <= div_in;
        upd_pend <= 1'b1;
      end else if (wrap) begin
        upd_pend <= 1'b0;
      end
    end else begin
      cnt      <= '0;
      clk_flag <= 1'b0;
      clk_sq   <= 1'b0;
      upd_pend <= 1'b0;
      if (div_load)      cur_div <= div_in;
      else if (upd_pend) cur_div <= pend_div;
    end
  end

endmodule

// File: tb/tb_clken_gen.sv
// Directed self-checking bench for clken_gen.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_clken_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div_val = '0;
  logic        div_load = 1'b0;
  logic        clk_flag;
  logic        clk_sq;
  logic        upd_pend;
  logic [7:0]  tick_cnt;
  logic [15:0] cur_div;

  int checks = 0;
  int errors = 0;

  clken_gen #(.CNT_W(16), .DEF_DIV(5), .TICK_W(8)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_flag (clk_flag),
    .clk_sq   (clk_sq),
    .upd_pend (upd_pend),
    .tick_cnt (tick_cnt),
    .cur_div  (cur_div)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    en = 1'b0;
    div_load = 1'b0;
    step();
    step();
    checks++;
    if ({clk_flag, clk_sq, upd_pend} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outs got %b exp 000", {clk_flag, clk_sq, upd_pend});
    end
    checks++;
    if (tick_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_tick got %0d exp 0", tick_cnt);
    end
    checks++;
    if (cur_div !== 16'd5) begin
      errors++;
      $display("FAIL reset_div got %0d exp 5", cur_div);
    end
  endtask

  task automatic test_default_div();
    logic ef, es;
    sys_rst_n = 1'b1;
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      ef = (k % 5 == 0);
      es = ((k % 5) < 3);
      checks++;
      if ({clk_flag, clk_sq} !== {ef, es}) begin
        errors++;
        $display("FAIL def_div edge %0d got %b exp %b", k, {clk_flag, clk_sq}, {ef, es});
      end
    end
    checks++;
    if (tick_cnt !== 8'd4) begin
      errors++;
      $display("FAIL def_tick got %0d exp 4", tick_cnt);
    end
  endtask

  task automatic test_div_update();
    logic [3:0] ef4, es4;
    ef4 = 4'b1000;
    es4 = 4'b1001;
    step();
    div_val = 16'd4;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({upd_pend, clk_flag, cur_div} !== {1'b1, 1'b0, 16'd5}) begin
        errors++;
        $display("FAIL upd_wait %0d got pend=%b flag=%b div=%0d exp 1 0 5",
                 i, upd_pend, clk_flag, cur_div);
      end
      if (i < 2) step();
    end
    step();
    checks++;
    if ({clk_flag, clk_sq, upd_pend, cur_div} !== {3'b110, 16'd4}) begin
      errors++;
      $display("FAIL upd_wrap got flag=%b sq=%b pend=%b div=%0d exp 1 1 0 4",
               clk_flag, clk_sq, upd_pend, cur_div);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({clk_flag, clk_sq} !== {ef4[i], es4[i]}) begin
        errors++;
        $display("FAIL upd_n4 %0d got %b exp %b", i, {clk_flag, clk_sq}, {ef4[i], es4[i]});
      end
    end
    checks++;
    if (tick_cnt !== 8'd6) begin
      errors++;
      $display("FAIL upd_tick got %0d exp 6", tick_cnt);
    end
  endtask

  task automatic test_coincident_load();
    div_val = 16'd3;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    step();
    step();
    checks++;
    if ({upd_pend, clk_flag} !== 2'b10) begin
      errors++;
      $display("FAIL coin_pre got pend=%b flag=%b exp 1 0", upd_pend, clk_flag);
    end
    div_val = 16'd7;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++;
    if ({clk_flag, clk_sq, upd_pend, cur_div} !== {3'b111, 16'd3}) begin
      errors++;
      $display("FAIL coin_wrap1 got flag=%b sq=%b pend=%b div=%0d exp 1 1 1 3",
               clk_flag, clk_sq, upd_pend, cur_div);
    end
    step();
    checks++;
    if ({clk_flag, clk_sq, upd_pend} !== 3'b011) begin
      errors++;
      $display("FAIL coin_n3a got %b exp 011", {clk_flag, clk_sq, upd_pend});
    end
    step();
    checks++;
    if ({clk_flag, clk_sq, upd_pend} !== 3'b001) begin
      errors++;
      $display("FAIL coin_n3b got %b exp 001", {clk_flag, clk_sq, upd_pend});
    end
    step();
    checks++;
    if ({clk_flag, clk_sq, upd_pend, cur_div} !== {3'b110, 16'd7}) begin
      errors++;
      $display("FAIL coin_wrap2 got flag=%b sq=%b pend=%b div=%0d exp 1 1 0 7",
               clk_flag, clk_sq, upd_pend, cur_div);
    end
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if ({clk_flag, clk_sq} !== {1'b0, (i < 4) ? 1'b1 : 1'b0}) begin
        errors++;
        $display("FAIL coin_n7 %0d got %b", i, {clk_flag, clk_sq});
      end
    end
    step();
    checks++;
    if ({clk_flag, tick_cnt} !== {1'b1, 8'd9}) begin
      errors++;
      $display("FAIL coin_end got flag=%b tick=%0d exp 1 9", clk_flag, tick_cnt);
    end
  endtask

  task automatic test_div_one();
    logic [7:0] exp_tick;
    en = 1'b0;
    div_val = 16'd0;
    div_load = 1'b1;
    step();
    checks++;
    if ({clk_flag, clk_sq, upd_pend, cur_div, tick_cnt} !== {3'b000, 16'd1, 8'd9}) begin
      errors++;
      $display("FAIL zero_load got flag=%b sq=%b pend=%b div=%0d tick=%0d exp 0 0 0 1 9",
               clk_flag, clk_sq, upd_pend, cur_div, tick_cnt);
    end
    en = 1'b1;
    div_val = 16'd1;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++;
    if ({clk_flag, clk_sq, upd_pend, tick_cnt} !== {3'b111, 8'd10}) begin
      errors++;
      $display("FAIL one_load got flag=%b sq=%b pend=%b tick=%0d exp 1 1 1 10",
               clk_flag, clk_sq, upd_pend, tick_cnt);
    end
    step();
    checks++;
    if ({upd_pend, cur_div, tick_cnt} !== {1'b0, 16'd1, 8'd11}) begin
      errors++;
      $display("FAIL one_commit got pend=%b div=%0d tick=%0d exp 0 1 11",
               upd_pend, cur_div, tick_cnt);
    end
    exp_tick = 8'd11;
    for (int i = 0; i < 244; i++) begin
      step();
      exp_tick = exp_tick + 8'd1;
      checks++;
      if ({clk_flag, clk_sq, tick_cnt} !== {2'b11, exp_tick}) begin
        errors++;
        $display("FAIL n1_run got flag=%b sq=%b tick=%0d exp 1 1 %0d",
                 clk_flag, clk_sq, tick_cnt, exp_tick);
      end
    end
    step();
    checks++;
    if (tick_cnt !== 8'd0) begin
      errors++;
      $display("FAIL tick_wrap got %0d exp 0", tick_cnt);
    end
  endtask

  task automatic test_enable_gap();
    en = 1'b0;
    div_val = 16'd5;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++;
    if ({clk_flag, clk_sq, cur_div, tick_cnt} !== {2'b00, 16'd5, 8'd0}) begin
      errors++;
      $display("FAIL gap_load got flag=%b sq=%b div=%0d tick=%0d exp 0 0 5 0",
               clk_flag, clk_sq, cur_div, tick_cnt);
    end
    en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (clk_flag !== (k == 5)) begin
        errors++;
        $display("FAIL gap_pre edge %0d got %b", k, clk_flag);
      end
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({clk_flag, clk_sq, tick_cnt} !== {2'b00, 8'd1}) begin
        errors++;
        $display("FAIL gap_off %0d got flag=%b sq=%b tick=%0d exp 0 0 1",
                 k, clk_flag, clk_sq, tick_cnt);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if ({clk_flag, clk_sq} !== {(k == 5) ? 1'b1 : 1'b0, ((k % 5) < 3) ? 1'b1 : 1'b0}) begin
        errors++;
        $display("FAIL gap_on edge %0d got %b", k, {clk_flag, clk_sq});
      end
    end
    checks++;
    if (tick_cnt !== 8'd2) begin
      errors++;
      $display("FAIL gap_tick got %0d exp 2", tick_cnt);
    end
  endtask

  task automatic test_reset_mid();
    div_val = 16'd9;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    checks++;
    if (upd_pend !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got pend=%b exp 1", upd_pend);
    end
    step();
    sys_rst_n = 1'b0;
    div_load = 1'b1;
    step();
    checks++;
    if ({clk_flag, clk_sq, upd_pend, tick_cnt, cur_div} !== {3'b000, 8'd0, 16'd5}) begin
      errors++;
      $display("FAIL rst_mid got flag=%b sq=%b pend=%b tick=%0d div=%0d exp 0 0 0 0 5",
               clk_flag, clk_sq, upd_pend, tick_cnt, cur_div);
    end
    sys_rst_n = 1'b1;
    div_load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (clk_flag !== (k == 5)) begin
        errors++;
        $display("FAIL rst_after edge %0d got %b", k, clk_flag);
      end
    end
    checks++;
    if ({upd_pend, cur_div} !== {1'b0, 16'd5}) begin
      errors++;
      $display("FAIL rst_discard got pend=%b div=%0d exp 0 5", upd_pend, cur_div);
    end
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_div_update();
    test_coincident_load();
    test_div_one();
    test_enable_gap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clken_gen.md
Name: clken_gen

Overview:
- Parametrised successor to the fixed-ratio clock-enable flag generator.
- Produces a one-cycle enable pulse (`clk_flag`) every N `sys_clk` cycles, plus a near-50% duty square output (`clk_sq`) and a wrapping count of issued pulses.
- The divisor N is programmable at run time through a shadow register. A new value takes effect only at a period boundary, so no period is ever truncated or stretched.
- Sits between the system clock and slow peripherals (debouncers, LED scanners, UART baud ticks) as their shared tick source.

Parameters:
- CNT_W, 16, width of divisor and period counter.
- DEF_DIV, 5, divisor loaded at reset; must satisfy 1 ≤ DEF_DIV < 2^CNT_W.
- TICK_W, 8, width of the pulse counter `tick_cnt`.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst_n  input  1  synchronous active-low reset.
- en  input  1  run enable; low holds and clears the period counter.
- div_val  input  CNT_W  requested divisor.
- div_load  input  1  one-cycle strobe; captures `div_val`.
- clk_flag  output  1  one-cycle enable pulse, once per period.
- clk_sq  output  1  square output, period N.
- upd_pend  output  1  high while a captured divisor awaits a period boundary.
- tick_cnt  output  TICK_W  count of `clk_flag` pulses issued, wraps.
- cur_div  output  CNT_W  divisor currently in effect.

Behaviour:
- Reset (`sys_rst_n` = 0 at a posedge) sets:
  - `cnt` = 0, `cur_div` = DEF_DIV, pending register = 0;
  - `upd_pend` = 0, `clk_flag` = 0, `clk_sq` = 0, `tick_cnt` = 0.
  - Reset asserted mid-period aborts the period; there is no partial pulse and any pending update is discarded.
- Effective divisor: N = max(`cur_div`, 1). A `div_val` of 0 is stored as 1.
- Each posedge with `en` = 1:
  - If `cnt` == N−1: `cnt` ← 0, `clk_flag` ← 1, `tick_cnt` ← `tick_cnt`+1 (modulo 2^TICK_W).
  - Otherwise: `cnt` ← `cnt`+1, `clk_flag` ← 0.
- `clk_flag` is registered. With `en` high from reset release, the first `clk_flag` is high after the N-th posedge, and thereafter high one cycle in every N.
- N = 1: `clk_flag` is constantly high while enabled.
- `clk_sq` ← `en` && (`cnt_next` < (N+1)>>1), where `cnt_next` is the value being written to `cnt` and N is the divisor in effect after the edge.
  - N even: exact 50% duty.
  - N odd: high one cycle longer than low.
  - N = 1: constant high while enabled.
- Each posedge with `en` = 0:
  - `cnt` ← 0, `clk_flag` ← 0, `clk_sq` ← 0.
  - `tick_cnt` holds.
- Re-assertion of `en`: counting restarts from `cnt` = 0. The first `clk_flag` comes N edges later.
- Divisor update, `en` = 1:
  - `div_load` writes the pending register and sets `upd_pend`.
  - At the next wrap edge (`cnt` == N−1), `cur_div` ← pending and `upd_pend` ← 0.
  - The new N governs the period that starts at that edge, including its `clk_sq` value.
- Divisor update, `en` = 0:
  - `div_load` writes `cur_div` directly at that edge; `upd_pend` stays 0.
- Simultaneous `div_load` and wrap edge:
  - The wrap applies the pending value held before the edge (if `upd_pend` = 1).
  - The newly captured value becomes pending and `upd_pend` is 1 after the edge. It applies at the following wrap.
- Multiple `div_load` strobes before a wrap: the last one wins. No FIFO.
- `en` falling while `upd_pend` = 1: the pending value is committed to `cur_div` on the first disabled edge and `upd_pend` clears.
- Reset has priority over `en` and `div_load`.

Test Plan:
- Reset, then `en` = 1 with DEF_DIV = 5 for 20 cycles → `clk_flag` high at the 5th, 10th, 15th and 20th posedge after release; `tick_cnt` = 4; `clk_sq` pattern 1,1,1,0,0 repeating.
- `div_load` with `div_val` = 4 at `cnt` = 1 (N = 5) → `upd_pend` = 1 for 3 cycles; the current period still lasts 5 cycles; the next period lasts 4 cycles; `clk_sq` is 1,1,0,0; `cur_div` = 4 after the wrap.
- `div_load` coincident with a wrap, with a previous pending value 3 and new value 7 → the next period uses 3, then 7; `upd_pend` is high across both captures until the second wrap.
- `div_val` = 0 and `div_val` = 1 → `cur_div` = 1; `clk_flag` and `clk_sq` constantly high while `en` = 1; `tick_cnt` increments every cycle and wraps 255→0 at TICK_W = 8.
- `en` dropped at `cnt` = 2, then raised 3 cycles later → `clk_flag` and `clk_sq` low while disabled; `tick_cnt` holds; first `clk_flag` N edges after re-enable.
- `sys_rst_n` pulsed low mid-period with `upd_pend` = 1 → next edge shows `cnt` = 0, `cur_div` = DEF_DIV, `upd_pend` = 0, `tick_cnt` = 0, all outputs 0.
